split_acc_bank: RTL
===================

# split_acc_bank

Multi-channel, pipelined split-carry adder-accumulator: signed input beats are summed into one of `NCH` independent accumulators, and the result is emitted when a beat is tagged `in_last`. The adder is split at `LO_W` bits. The low half is added in stage 1, and the high half is added in stage 2 with the registered carry, so the critical path is roughly half the accumulator width. It sits behind the MV-product datapath and reduces per-row partial products for several interleaved rows (channels) without stalling.

## Interface
- `IN_W`, 24, input operand width (signed)
- `ACC_W`, 24, accumulator width; `ACC_W >= IN_W`; input is sign-extended to `ACC_W`
- `LO_W`, 12, low-segment width; `1 <= LO_W < ACC_W`; high segment is `ACC_W-LO_W`
- `NCH`, 4, number of independent accumulators; `CH_W = max(1, clog2(NCH))`

Ports:
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-high reset
- `in_valid` in 1: beat present this cycle
- `in_ch` in `CH_W`: target channel
- `in_first` in 1: beat starts a new sum; stored value treated as 0
- `in_last` in 1: beat ends the sum; result is emitted
- `in_data` in `IN_W`: signed operand
- `out_valid` out 1: result strobe, one cycle per `in_last` beat
- `out_ch` out `CH_W`: channel of result
- `out_data` out `ACC_W`: signed sum (two's complement, wraps)
- `out_ovf` out 1: present only with `SPLIT_ACC_OVF_EN`; see Configuration

## Operation
- No backpressure. A beat is accepted every cycle that `in_valid` is high.
- Beats with `in_ch >= NCH` are dropped: no state change and no output.
- **Stage 1 (cycle t):**
  - Low sum = `in_data_ext[LO_W-1:0]` + (`in_first ? 0 : lo[in_ch]`).
  - `lo[in_ch]` ← sum[`LO_W-1`:0].
  - Register the following into stage-2 pipeline registers: carry = sum[`LO_W`], high operand `in_data_ext[ACC_W-1:LO_W]`, `first`, `last`, `ch`, and the low result.
- **Stage 2 (cycle t+1):**
  - High sum = high operand + (`first ? 0 : hi[ch]`) + carry.
  - `hi[ch]` ← high sum.
  - If `last`, register the output bundle.
- **Same-channel back-to-back beats need no stall or forward.**
  - Stage 1 reads `lo[ch]` as written by the previous cycle's stage 1.
  - Stage 2 reads `hi[ch]` as written by the previous cycle's stage 2.
  - The carry travels with its beat.
- `in_first` and `in_last` on the same beat: result = `in_data` sign-extended.
- Beats to a channel after `in_last` without `in_first` continue from the emitted sum; the accumulator is not auto-cleared.
- Overflow wraps modulo 2^`ACC_W`.

## Timing
- Latency: `in_valid`&`in_last` sampled at edge t → `out_valid` high during cycle t+2, for exactly one cycle.
- Throughput: 1 beat/cycle on any channel mix; results may appear on consecutive cycles.
- `out_data` and `out_ch` hold their last value when `out_valid` is low.
- Reset (asserted at any time, including mid-pipeline):
  - Clears all `lo`/`hi`, pipeline valids, `out_valid`, `out_ch`, `out_data`, and `out_ovf` to 0.
  - In-flight beats are discarded; no `out_valid` is produced for them.
- First edge after reset deassertion may accept a beat.

## Configuration
- `SPLIT_ACC_OVF_EN` defined:
  - Adds a per-channel sticky signed-overflow flag.
  - Set in stage 2 when both accumulator operands (high input with sign and the stored `hi`, or 0 on `in_first`) have equal sign and the high result sign differs.
  - Cleared by `in_first`, but set again if that same beat overflows.
  - Presented on `out_ovf` alongside `out_valid`; resets to 0.
- Not defined:
  - The `out_ovf` port and the flag storage are absent.
  - Arithmetic is unchanged.

## Test plan
- **Carry across split (defaults):** ch0 `first` 0x000FFF, then `last` 0x000001 → `out_valid` at t+2, `out_ch`=0, `out_data`=0x001000.
- **Interleaved channels, back-to-back:**
  - ch0 `first`=5, ch1 `first`=-3, ch0=7, ch1 `last`=-4, ch0 `last`=1.
  - Expected: ch1 result -7 (0xFFFFF9) in one cycle, ch0 result 13 in the next.
- **Single-beat sum:** `first`&`last` with `in_data`=0x800000 → `out_data`=0x800000, 2-cycle latency.
- **Wrap plus overflow:**
  - ch2 `first` 0x7FFFFF, `last` 0x000001 → `out_data`=0x800000.
  - With `SPLIT_ACC_OVF_EN`: `out_ovf`=1.
  - Next `first`&`last`=1 → `out_ovf`=0.
- **Reset mid-flight:** assert `reset` one cycle after a `last` beat → no `out_valid`; subsequent non-`first` beat of 3 with `last` → `out_data`=3.
- **Invalid channel:** with `NCH`=3, beat to `in_ch`=3 → no output and no state change in ch0–2.

Source files
------------

// File: rtl/split_acc_bank_if.sv
// Beat-in / result-out bundle for split_acc_bank.
// The out_ovf signal exists only when SPLIT_ACC_OVF_EN is defined.
interface split_acc_bank_if #(
    parameter int IN_W  = 24,
    parameter int ACC_W = 24,
    parameter int NCH   = 4
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    // in_valid alone qualifies a beat: there is no ready, so every cycle with
    // in_valid high consumes the beat. out_valid is a one-cycle result strobe;
    // out_ch/out_data keep their last value while out_valid is low.
    logic             in_valid;
    logic [CH_W-1:0]  in_ch;
    logic             in_first;
    logic             in_last;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic [CH_W-1:0]  out_ch;
    logic [ACC_W-1:0] out_data;
`ifdef SPLIT_ACC_OVF_EN
    logic             out_ovf;

    modport master (
        output in_valid, in_ch, in_first, in_last, in_data,
        input  out_valid, out_ch, out_data, out_ovf
    );
    modport slave (
        input  in_valid, in_ch, in_first, in_last, in_data,
        output out_valid, out_ch, out_data, out_ovf
    );
`else
    modport master (
        output in_valid, in_ch, in_first, in_last, in_data,
        input  out_valid, out_ch, out_data
    );
    modport slave (
        input  in_valid, in_ch, in_first, in_last, in_data,
        output out_valid, out_ch, out_data
    );
`endif
endinterface

// File: rtl/split_acc_bank.sv
// Multi-channel two-stage split-carry accumulator: low segment in stage 1, high
// segment plus registered carry in stage 2. SPLIT_ACC_OVF_EN adds sticky overflow.
module split_acc_bank #(
    parameter int IN_W  = 24,
    parameter int ACC_W = 24,
    parameter int LO_W  = 12,
    parameter int NCH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    split_acc_bank_if.slave bus
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int HI_W = ACC_W - LO_W;
    localparam logic [CH_W:0] NCH_L = (CH_W + 1)'(NCH);

    logic [LO_W-1:0]  lo_q [NCH];
    logic [HI_W-1:0]  hi_q [NCH];

    logic             in_ok;
    logic [ACC_W-1:0] in_ext;
    logic [LO_W-1:0]  lo_base;
    logic [LO_W:0]    lo_sum;

    logic             s2_valid;
    logic             s2_first;
    logic             s2_last;
    logic [CH_W-1:0]  s2_ch;
    logic             s2_carry;
    logic [HI_W-1:0]  s2_hi_op;
    logic [LO_W-1:0]  s2_lo;

    logic [HI_W-1:0]  hi_base;
    logic [HI_W-1:0]  hi_sum;

    logic             out_valid_q;
    logic [CH_W-1:0]  out_ch_q;
    logic [ACC_W-1:0] out_data_q;

    // Out-of-range channels are dropped here, so nothing downstream sees them.
    assign in_ok  = bus.in_valid && ({1'b0, bus.in_ch} < NCH_L);
    assign in_ext = ACC_W'($signed(bus.in_data));

    always_comb begin
        lo_base = '0;
        if (in_ok && !bus.in_first) begin
            lo_base = lo_q[bus.in_ch];
        end
    end

    assign lo_sum = {1'b0, in_ext[LO_W-1:0]} + {1'b0, lo_base};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                lo_q[i] <= '0;
            end
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_ch    <= '0;
            s2_carry <= 1'b0;
            s2_hi_op <= '0;
            s2_lo    <= '0;
        end else begin
            s2_valid <= in_ok;
            if (in_ok) begin
                lo_q[bus.in_ch] <= lo_sum[LO_W-1:0];
                s2_first        <= bus.in_first;
                s2_last         <= bus.in_last;
                s2_ch           <= bus.in_ch;
                s2_carry        <= lo_sum[LO_W];
                s2_hi_op        <= in_ext[ACC_W-1:LO_W];
                s2_lo           <= lo_sum[LO_W-1:0];
            end
        end
    end

    // hi_q was written by the previous beat's stage 2, so same-channel
    // back-to-back beats see the up-to-date high half without forwarding.
    always_comb begin
        hi_base = s2_first ? '0 : hi_q[s2_ch];
        hi_sum  = s2_hi_op + hi_base + HI_W'(s2_carry);
    end

`ifdef SPLIT_ACC_OVF_EN
    logic ovf_q [NCH];
    logic ovf_now;
    logic ovf_new;
    logic out_ovf_q;

    assign ovf_now = (s2_hi_op[HI_W-1] == hi_base[HI_W-1]) &&
                     (hi_sum[HI_W-1] != s2_hi_op[HI_W-1]);
    assign ovf_new = (s2_first ? 1'b0 : ovf_q[s2_ch]) | ovf_now;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                ovf_q[i] <= 1'b0;
            end
            out_ovf_q <= 1'b0;
        end else if (s2_valid) begin
            ovf_q[s2_ch] <= ovf_new;
            if (s2_last) begin
                out_ovf_q <= ovf_new;
            end
        end
    end

    assign bus.out_ovf = out_ovf_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                hi_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= s2_valid && s2_last;
            if (s2_valid) begin
                hi_q[s2_ch] <= hi_sum;
                if (s2_last) begin
                    out_ch_q   <= s2_ch;
                    out_data_q <= {hi_sum, s2_lo};
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_data  = out_data_q;
endmodule
